// File: rtl/plic_claim_ctrl.sv
// plic_claim_ctrl: hardware claim/complete sequencer between the CPU bus and the PLIC port.
// Performs the claim read on external_irq, presents the ID as a vectored request,
// issues the complete write on end-of-service (or watchdog expiry), and arbitrates
// the single PLIC port against CPU pass-through traffic.
// Optional statistics counters are built when PLIC_CTRL_STATS_EN is defined.
module plic_claim_ctrl #(
  parameter logic [31:0] PLIC_BASE   = 32'h0C00_0000,
  parameter int unsigned ID_W        = 5,
  parameter int unsigned MAX_SERVICE = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic [3:0]       cpu_wstrb,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ready,
  output logic [31:0]      plic_addr,
  output logic [31:0]      plic_wdata,
  output logic [3:0]       plic_wstrb,
  output logic             plic_read_en,
  input  logic [31:0]      plic_rdata,
  input  logic             plic_irq,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  output logic             busy,
  output logic             timeout_pulse,
  output logic [CNT_W-1:0] claim_count,
  output logic [CNT_W-1:0] spurious_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam logic [31:0] CLAIM_ADDR = PLIC_BASE + 32'h0020_0004;
  localparam int unsigned SVC_W      = $clog2(MAX_SERVICE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLAIM,
    S_PRESENT,
    S_SERVICE,
    S_COMPLETE
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_timeout;
  logic [ID_W-1:0]  r_irq_id;
  logic             r_irq_valid;
  logic             r_busy;
  logic             r_timeout_pulse;
  logic [SVC_W-1:0] r_svc_cnt;

  logic             w_claim_hit;
  logic             w_cpu_wr;
  logic [ID_W-1:0]  w_id_claimed;
  logic             w_cpu_eoi;
  logic             w_svc_expire;

  assign w_claim_hit  = (cpu_addr == CLAIM_ADDR);
  assign w_cpu_wr     = |cpu_wstrb;
  assign w_id_claimed = plic_rdata[ID_W-1:0];
  // A CPU write of the current ID to the claim register ends service like irq_eoi.
  assign w_cpu_eoi    = cpu_req & w_claim_hit & w_cpu_wr & (cpu_wdata[ID_W-1:0] == r_irq_id);
  assign w_svc_expire = (r_svc_cnt == SVC_W'(MAX_SERVICE - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; eoi takes priority over watchdog expiry
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:     if (plic_irq) w_state_nxt = S_CLAIM;
      S_CLAIM:    w_state_nxt = (w_id_claimed != '0) ? S_PRESENT : S_IDLE;
      S_PRESENT:  if (irq_ack) w_state_nxt = irq_eoi ? S_COMPLETE : S_SERVICE;
      S_SERVICE: begin
        if (irq_eoi || w_cpu_eoi) begin
          w_state_nxt = S_COMPLETE;
        end else if (w_svc_expire) begin
          w_state_nxt = S_COMPLETE;
          w_timeout   = 1'b1;
        end
      end
      S_COMPLETE: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Registered status outputs, claimed ID and service watchdog counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_id        <= '0;
      r_irq_valid     <= 1'b0;
      r_busy          <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_svc_cnt       <= '0;
    end else begin
      if (r_state == S_CLAIM) r_irq_id <= w_id_claimed;
      r_irq_valid     <= (w_state_nxt == S_PRESENT) || (w_state_nxt == S_SERVICE);
      r_busy          <= (w_state_nxt != S_IDLE);
      r_timeout_pulse <= w_timeout;
      r_svc_cnt       <= (r_state == S_SERVICE) ? r_svc_cnt + SVC_W'(1) : '0;
    end
  end

  assign irq_id        = r_irq_id;
  assign irq_valid     = r_irq_valid;
  assign busy          = r_busy;
  assign timeout_pulse = r_timeout_pulse;

  // PLIC port mux: controller owns it in CLAIM/COMPLETE, else CPU pass-through with claim interception
  always_comb begin
    plic_addr    = '0;
    plic_wdata   = '0;
    plic_wstrb   = '0;
    plic_read_en = 1'b0;
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    case (r_state)
      S_CLAIM: begin
        plic_addr    = CLAIM_ADDR;
        plic_read_en = 1'b1;
      end
      S_COMPLETE: begin
        plic_addr  = CLAIM_ADDR;
        plic_wdata = 32'(r_irq_id);
        plic_wstrb = 4'hF;
      end
      default: begin
        cpu_ready = cpu_req;
        if (cpu_req) begin
          if (w_claim_hit) begin
            if (!w_cpu_wr && ((r_state == S_PRESENT) || (r_state == S_SERVICE)))
              cpu_rdata = 32'(r_irq_id);
          end else begin
            plic_addr    = cpu_addr;
            plic_wdata   = cpu_wdata;
            plic_wstrb   = cpu_wstrb;
            plic_read_en = ~w_cpu_wr;
            cpu_rdata    = plic_rdata;
          end
        end
      end
    endcase
  end

`ifdef PLIC_CTRL_STATS_EN
  logic [CNT_W-1:0] r_claim_cnt;
  logic [CNT_W-1:0] r_spur_cnt;
  logic [CNT_W-1:0] r_tout_cnt;

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_claim_cnt <= '0;
      r_spur_cnt  <= '0;
      r_tout_cnt  <= '0;
    end else begin
      if ((r_state == S_CLAIM) && (w_id_claimed != '0) && (r_claim_cnt != {CNT_W{1'b1}}))
        r_claim_cnt <= r_claim_cnt + CNT_W'(1);
      if ((r_state == S_CLAIM) && (w_id_claimed == '0) && (r_spur_cnt != {CNT_W{1'b1}}))
        r_spur_cnt <= r_spur_cnt + CNT_W'(1);
      if (w_timeout && (r_tout_cnt != {CNT_W{1'b1}}))
        r_tout_cnt <= r_tout_cnt + CNT_W'(1);
    end
  end

  assign claim_count    = r_claim_cnt;
  assign spurious_count = r_spur_cnt;
  assign timeout_count  = r_tout_cnt;
`else
  assign claim_count    = '0;
  assign spurious_count = '0;
  assign timeout_count  = '0;
`endif

endmodule
